// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with show-ahead receive FIFO and sticky error flags
//
// Ports:
//   clk        SoC clock
//   rst_n      asynchronous active-low reset
//   uart_rx    raw serial line, idle high, asynchronous to clk
//   rd_data    head-of-FIFO byte (show-ahead), zero while rd_valid=0
//   rd_valid   FIFO not empty
//   rd_ready   pops the head byte on an edge where rd_valid && rd_ready
//   count      number of bytes queued (0..depth)
//   overrun    sticky: a received byte was dropped because the FIFO was full
//   frame_err  sticky: a stop bit was sampled low
//   err_clr    clears overrun and frame_err (a same-cycle set wins)
module uart_rx_fifo #(
  parameter int CLK_FREQ        = 20_250_000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_ADDR_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       uart_rx,
  output logic [7:0]                 rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [FIFO_ADDR_WIDTH:0]   count,
  output logic                       overrun,
  output logic                       frame_err,
  input  logic                       err_clr
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int DEPTH        = 1 << FIFO_ADDR_WIDTH;
  localparam int TW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FIFO_ADDR_WIDTH:0] C_FULL = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic                       rx_meta;
  logic                       rxs;
  logic [2:0]                 state;
  logic [TW-1:0]              timer;
  logic [2:0]                 idx;
  logic [7:0]                 shreg;
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;

  logic bit_end;
  logic stop_ok;
  logic stop_bad;
  logic full;
  logic do_pop;
  logic do_push;
  logic drop;

  assign bit_end  = (timer == T_FULL);
  assign stop_ok  = (state == ST_STOP) && bit_end && rxs;
  assign stop_bad = (state == ST_STOP) && bit_end && !rxs;
  assign full     = (count == C_FULL);
  assign rd_valid = (count != '0);
  assign do_pop   = rd_valid && rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push  = stop_ok && (!full || do_pop);
  assign drop     = stop_ok && full && !do_pop;
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

  // Two-flop synchronizer; reset to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      timer <= '0;
      idx   <= 3'd0;
      shreg <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            timer <= '0;
            state <= ST_START;
          end
        end
        ST_START: begin
          // Mid-bit check rejects glitches shorter than half a bit.
          if (timer == T_HALF) begin
            if (rxs) begin
              state <= ST_IDLE;
            end else begin
              timer <= '0;
              idx   <= 3'd0;
              state <= ST_DATA;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            timer      <= '0;
            shreg[idx] <= rxs;
            if (idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            timer <= '0;
            state <= rxs ? ST_IDLE : ST_BREAK;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_BREAK: begin
          // Hold here so a line stuck low reports one error, not 0x00 bytes.
          if (rxs) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Storage has no reset; rd_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
      if (stop_bad) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard testbench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] count;
  logic       overrun;
  logic       frame_err;
  logic       err_clr;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(
    .CLK_FREQ(1_600_000),
    .BAUD_RATE(100_000),
    .FIFO_ADDR_WIDTH(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .uart_rx(uart_rx),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .count(count),
    .overrun(overrun),
    .frame_err(frame_err),
    .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800_000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the stop period.
  task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_cycles);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_val;
    repeat (stop_cycles) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(b);
    send_byte(b, 1'b1, CPB);
  endtask

  task automatic read_one(input string tag);
    int n = 0;
    while (!rd_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_sb"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      chk({tag, "_data"}, 32'(rd_data), 32'(exp_q.pop_front()));
    end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    uart_rx  = 1'b1;
    rd_ready = 1'b0;
    err_clr  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'h00);
    chk("rst_flags", 32'({overrun, frame_err}), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte, exact latency from the pin edge.
    exp_q.push_back(8'hA5);
    fork
      send_byte(8'hA5, 1'b1, CPB);
      begin
        repeat (154) @(negedge clk);
        chk("t1_not_yet", 32'(rd_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(rd_valid), 32'd1);
        chk("t1_data", 32'(rd_data), 32'hA5);
        chk("t1_count", 32'(count), 32'd1);
      end
    join
    chk("t1_flags", 32'({overrun, frame_err}), 32'd0);
    read_one("t1_rd");
    chk("t1_empty", 32'(count), 32'd0);

    // Back-to-back bytes, drained in order.
    send_good(8'h00);
    send_good(8'hFF);
    send_good(8'h3C);
    repeat (4) @(negedge clk);
    chk("t2_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) read_one("t2_rd");
    chk("t2_valid", 32'(rd_valid), 32'd0);
    chk("t2_count0", 32'(count), 32'd0);

    // Overflow: ninth byte dropped.
    for (int i = 1; i <= 8; i++) send_good(8'(i));
    send_byte(8'h09, 1'b1, CPB);
    repeat (4) @(negedge clk);
    chk("t3_count", 32'(count), 32'd8);
    chk("t3_overrun", 32'(overrun), 32'd1);
    for (int i = 0; i < 8; i++) read_one("t3_rd");
    chk("t3_ovr_held", 32'(overrun), 32'd1);
    pulse_clr();
    chk("t3_ovr_clr", 32'(overrun), 32'd0);

    // Full FIFO with a pop on the push edge.
    for (int i = 0; i < 8; i++) send_good(8'(8'h10 + i));
    chk("t4_full", 32'(count), 32'd8);
    fork
      send_byte(8'h55, 1'b1, CPB);
      begin
        repeat (154) @(negedge clk);
        chk("t4_head", 32'(rd_data), 32'(exp_q.pop_front()));
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk("t4_count_edge", 32'(count), 32'd8);
      end
    join
    exp_q.push_back(8'h55);
    chk("t4_count", 32'(count), 32'd8);
    chk("t4_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 8; i++) read_one("t4_rd");
    chk("t4_drained", 32'(count), 32'd0);

    // Short glitch, then a framing error with a held-low line.
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("t5_glitch_cnt", 32'(count), 32'd0);
    chk("t5_glitch_flg", 32'({overrun, frame_err}), 32'd0);
    send_byte(8'h81, 1'b0, 40);
    repeat (CPB) @(negedge clk);
    chk("t5_ferr", 32'(frame_err), 32'd1);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_ovr", 32'(overrun), 32'd0);
    send_good(8'h42);
    repeat (4) @(negedge clk);
    chk("t5_count1", 32'(count), 32'd1);
    read_one("t5_rd");
    pulse_clr();
    chk("t5_ferr_clr", 32'(frame_err), 32'd0);

    // Reset mid-frame with bytes queued.
    send_good(8'h11);
    send_good(8'h22);
    send_good(8'h33);
    chk("t6_queued", 32'(count), 32'd3);
    fork
      send_byte(8'h99, 1'b1, CPB);
      begin
        repeat (CPB * 5 + 8) @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_valid", 32'(rd_valid), 32'd0);
        chk("t6_rst_flags", 32'({overrun, frame_err}), 32'd0);
      end
    join
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_idle_cnt", 32'(count), 32'd0);
    send_good(8'h7E);
    repeat (4) @(negedge clk);
    chk("t6_count1", 32'(count), 32'd1);
    read_one("t6_rd");
    chk("t6_flags", 32'({overrun, frame_err}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 8N1 UART receiver with a buffered receive FIFO; the receive-side counterpart of the SoC's UART transmit path.
- Sits inside the SoC between the board-level uart_rx pin and the memory-mapped UART register block.
- Oversamples the asynchronous line, reassembles bytes LSB-first and queues them.
- The CPU drains bytes through a valid/ready read port; overrun and framing errors are flagged sticky.

Parameters:
- CLK_FREQ, 20_250_000, clk frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide, 175 at defaults).
- FIFO_ADDR_WIDTH, 3, FIFO depth = 2**FIFO_ADDR_WIDTH entries (8 at default).

Ports:
- clk  in  1  SoC clock.
- rst_n  in  1  asynchronous active-low reset.
- uart_rx  in  1  raw serial line, idle high, asynchronous to clk.
- rd_data  out  8  head-of-FIFO byte (show-ahead); valid only while rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer pops the head byte on a clk edge where rd_valid && rd_ready.
- count  out  FIFO_ADDR_WIDTH+1  number of bytes queued.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.
- frame_err  out  1  sticky: a stop bit was sampled low.
- err_clr  in  1  clears overrun and frame_err on the next edge.

Behaviour:
- Reset (async assert, synchronous deassert handled upstream): FSM=IDLE, synchronizer FFs=1, rd_valid=0, count=0, rd_data=0, overrun=0, frame_err=0, read/write pointers=0.
- Input conditioning: two-flop synchronizer on uart_rx; the FSM sees only the second-stage output rxs.
- Bit timer: counter 0..CLKS_PER_BIT-1.
- Bit index: 3-bit counter.
- Shift register: 8 bits, filled LSB-first.

FSM states and transitions:
- IDLE: when rxs=0, clear the timer and go to START.
- START: at timer = CLKS_PER_BIT/2-1, sample rxs.
  - If rxs=1 (glitch/false start), return to IDLE; nothing is queued.
  - Otherwise clear the timer and bit index and go to DATA.
- DATA: at timer = CLKS_PER_BIT-1, shift rxs into bit[index]. After index 7, go to STOP.
- STOP: at timer = CLKS_PER_BIT-1, sample rxs.
  - If rxs=1, push the byte and go to IDLE.
  - If rxs=0, set frame_err, discard the byte and go to BREAK.
- BREAK: stay until rxs=1, then go to IDLE. A held-low line yields exactly one frame_err event, never a byte stream.

FIFO:
- Push: occurs in the STOP-sample cycle. rd_valid rises on the following edge.
- Latency from the first synchronized low to rd_valid is CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, plus 2 cycles of synchronizer delay from the pin.
- Pop: on rd_valid && rd_ready. rd_data updates to the next entry on the same edge.
- Pop while empty: ignored; count does not underflow.
- Push while full with no pop: byte dropped, overrun set, FIFO contents and count unchanged.
- Push while full with a simultaneous pop: both take effect, count stays at full, overrun not set.
- Push on empty with a simultaneous pop: impossible, because rd_valid=0.
- Pointers: wrap modulo depth. count ranges 0..2**FIFO_ADDR_WIDTH.

Error flags:
- err_clr has priority below a same-cycle set event: the set wins and the flag stays 1.
- Errors never block reception.

Reset mid-frame: all state returns to reset values immediately; the partial byte and all queued bytes are lost. After release, the receiver waits in IDLE for the next falling edge. A line that is already low at release is treated as a start bit.

Test Plan:
(Sim params: CLK_FREQ=1_600_000, BAUD_RATE=100_000, giving CLKS_PER_BIT=16.)
- Send 0xA5 with rd_ready=0 -> rd_valid=1, rd_data=0xA5, count=1 within 8+144+3 cycles of the start edge; no error flags.
- Send 0x00, 0xFF, 0x3C back-to-back, then pulse rd_ready three times -> reads 0x00, 0xFF, 0x3C in order; rd_valid=0 and count=0 afterwards.
- Send 9 bytes 0x01..0x09 with no reads -> count=8, overrun=1, reads return 0x01..0x08. Then assert err_clr -> overrun=0.
- Fill the FIFO with 8 bytes, then hold rd_ready=1 on the STOP-sample edge of a 9th byte 0x55 -> count stays 8, overrun=0, 0x55 is the last byte read.
- 4-cycle low glitch on uart_rx -> no push, no flags. Frame 0x81 with a low stop bit held 40 cycles -> frame_err=1, count=0, exactly one error; a following 0x42 is received correctly.
- Assert rst_n=0 during bit 4 of a frame with 3 bytes queued -> count=0, rd_valid=0, flags=0 immediately. After release, the next frame 0x7E is received correctly.
